// File: rtl/result_view.sv
// result_view: latches player scores, finds the top score and its holders,
// scrolls every score across the display, then shows the winner(s).
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   view           view selector; the block runs while view == VIEW_ID
//   player_count   number of active players, limited to MAX_PLAYERS
//   scores         packed scores; player i occupies slice i-1
//   digits         eight 4-bit codes, digit 0 in [3:0]; 4'hF means blank
//   led            bit i-1 lights for player i
//   buzzer         beeps briefly on entry to the result screen
//   result_valid   high on the result screen and on the empty screen
module result_view #(
  parameter int MAX_PLAYERS = 4,
  parameter int SCORE_W     = 7,
  parameter int TICK_CYCLES = 10_000_000,
  parameter int STEP_TICKS  = 10,
  parameter int BEEP_TICKS  = 5,
  parameter int VIEW_ID     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [2:0]                     view,
  input  logic [2:0]                     player_count,
  input  logic [MAX_PLAYERS*SCORE_W-1:0] scores,
  output logic [31:0]                    digits,
  output logic [23:0]                    led,
  output logic                           buzzer,
  output logic                           result_valid
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int BW = (BEEP_TICKS > 0) ? $clog2(BEEP_TICKS + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);
  localparam logic [BW-1:0] BEEP_END  = BW'(BEEP_TICKS);
  localparam logic [2:0]    VIEW_SEL  = 3'(VIEW_ID);
  localparam logic [3:0]    MAXP      = 4'(MAX_PLAYERS);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_COMPUTE, S_SCROLL, S_RESULT, S_EMPTY
  } state_t;

  state_t               r_state, n_state;
  logic [SCORE_W-1:0]   r_snap [8];
  logic [SCORE_W-1:0]   n_snap [8];
  logic [SCORE_W-1:0]   w_sc   [8];
  logic [SCORE_W-1:0]   r_max, n_max;
  logic [7:0]           r_mask, n_mask;
  logic [3:0]           r_cnt, n_cnt;
  logic [2:0]           r_idx, n_idx;
  logic [2:0]           r_p, n_p;
  logic [2:0]           r_pos, n_pos;
  logic [2:0]           r_win, n_win;
  logic [2:0]           r_blk, n_blk;
  logic                 r_phase, n_phase;
  logic [TW-1:0]        r_tick, n_tick;
  logic [SW-1:0]        r_step, n_step;
  logic [BW-1:0]        r_beep, n_beep;
  logic [31:0]          r_dig, n_dig;
  logic [23:0]          r_led, n_led;
  logic                 r_buz, n_buz;
  logic                 r_rv, n_rv;

  logic [3:0]           w_cnt;
  logic                 w_tick_ev;
  logic                 w_step_ev;
  logic                 w_multi;
  logic [7:0]           w_bcd;
  logic [4:0]           w_base;
  logic [3:0]           w_nw;

  // Unused player slots read as zero so the snapshot is always 8 deep.
  for (genvar g = 0; g < 8; g++) begin : g_sc
    if (g < MAX_PLAYERS) begin : g_on
      assign w_sc[g] = scores[g*SCORE_W +: SCORE_W];
    end else begin : g_off
      assign w_sc[g] = '0;
    end
  end

  function automatic logic [7:0] bcd(input logic [SCORE_W-1:0] s);
    logic [6:0] v;
    if (32'(s) > 32'd99) v = 7'd99;
    else v = 7'(s);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic [2:0] first_bit(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) r = 3'(i);
    return r;
  endfunction

  // Next set bit above w, wrapping past bit 7.
  function automatic logic [2:0] next_bit(input logic [7:0] m,
                                          input logic [2:0] w);
    logic [2:0] r;
    logic [2:0] j;
    logic       hit;
    r   = w;
    hit = 1'b0;
    for (int k = 1; k < 8; k++) begin
      j = w + 3'(k);
      if (!hit && m[j]) begin
        r   = j;
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  assign w_cnt = ({1'b0, player_count} > MAXP) ? MAXP
                                               : {1'b0, player_count};
  assign w_tick_ev = (r_tick == TICK_LAST);
  assign w_step_ev = w_tick_ev && (r_step == STEP_LAST);
  assign w_multi   = ($countones(r_mask) > 1);

  always_comb begin
    n_state = r_state;
    n_snap  = r_snap;
    n_cnt   = r_cnt;
    n_idx   = r_idx;
    n_max   = r_max;
    n_mask  = r_mask;
    n_p     = r_p;
    n_pos   = r_pos;
    n_tick  = r_tick;
    n_step  = r_step;
    n_beep  = r_beep;
    n_blk   = r_blk;
    n_phase = r_phase;
    n_win   = r_win;
    unique case (r_state)
      S_IDLE: begin
        if (view == VIEW_SEL) n_state = S_LATCH;
      end
      S_LATCH: begin
        n_snap  = w_sc;
        n_cnt   = w_cnt;
        n_idx   = '0;
        n_max   = '0;
        n_mask  = '0;
        n_state = (w_cnt == 4'd0) ? S_EMPTY : S_COMPUTE;
      end
      S_COMPUTE: begin
        if (r_snap[r_idx] > r_max) begin
          n_max  = r_snap[r_idx];
          n_mask = 8'b1 << r_idx;
        end else if (r_snap[r_idx] == r_max) begin
          n_mask = r_mask | (8'b1 << r_idx);
        end
        n_idx = r_idx + 3'd1;
        if ({1'b0, r_idx} == r_cnt - 4'd1) begin
          n_state = S_SCROLL;
          n_p     = '0;
          n_pos   = '0;
          n_tick  = '0;
          n_step  = '0;
        end
      end
      S_SCROLL: begin
        n_tick = w_tick_ev ? '0 : r_tick + TW'(1);
        if (w_tick_ev)
          n_step = w_step_ev ? '0 : r_step + SW'(1);
        if (w_step_ev) begin
          if (r_pos == 3'd5) begin
            n_pos = '0;
            if ({1'b0, r_p} == r_cnt - 4'd1) begin
              n_state = S_RESULT;
              n_win   = first_bit(r_mask);
              n_tick  = '0;
              n_step  = '0;
              n_beep  = '0;
              n_blk   = '0;
              n_phase = 1'b1;
            end else begin
              n_p = r_p + 3'd1;
            end
          end else begin
            n_pos = r_pos + 3'd1;
          end
        end
      end
      S_RESULT: begin
        n_tick = w_tick_ev ? '0 : r_tick + TW'(1);
        if (w_tick_ev) begin
          n_step = w_step_ev ? '0 : r_step + SW'(1);
          if (r_beep != BEEP_END) n_beep = r_beep + BW'(1);
          if (r_blk == 3'd4) begin
            n_blk   = '0;
            n_phase = ~r_phase;
          end else begin
            n_blk = r_blk + 3'd1;
          end
        end
        if (w_step_ev && w_multi) n_win = next_bit(r_mask, r_win);
      end
      S_EMPTY: ;
      default: n_state = S_IDLE;
    endcase
    if (r_state != S_IDLE && view != VIEW_SEL) n_state = S_IDLE;
  end

  // Outputs are decoded from the next-state values so the registered
  // outputs line up with the state they describe.
  always_comb begin
    n_dig  = '1;
    n_led  = '0;
    n_buz  = 1'b0;
    n_rv   = 1'b0;
    w_base = {n_pos, 2'b00};
    w_bcd  = bcd((n_state == S_RESULT) ? n_max : n_snap[n_p]);
    w_nw   = 4'($countones(n_mask));
    unique case (1'b1)
      (n_state == S_SCROLL): begin
        if (n_pos < 3'd5) begin
          n_dig[w_base +: 4]         = {1'b0, n_p} + 4'd1;
          n_dig[w_base + 5'd8 +: 4]  = w_bcd[7:4];
          n_dig[w_base + 5'd12 +: 4] = w_bcd[3:0];
        end
      end
      (n_state == S_RESULT): begin
        n_rv          = 1'b1;
        n_dig[19:16]  = {1'b0, n_win} + 4'd1;
        n_dig[27:24]  = w_bcd[7:4];
        n_dig[31:28]  = w_bcd[3:0];
        if (w_nw > 4'd1) n_dig[3:0] = w_nw;
        n_led = n_phase ? {16'h0, n_mask} : '0;
        n_buz = (n_beep != BEEP_END);
      end
      (n_state == S_EMPTY): n_rv = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      for (int i = 0; i < 8; i++) r_snap[i] <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_max   <= '0;
      r_mask  <= '0;
      r_p     <= '0;
      r_pos   <= '0;
      r_tick  <= '0;
      r_step  <= '0;
      r_beep  <= '0;
      r_blk   <= '0;
      r_phase <= 1'b0;
      r_win   <= '0;
      r_dig   <= '1;
      r_led   <= '0;
      r_buz   <= 1'b0;
      r_rv    <= 1'b0;
    end else begin
      r_state <= n_state;
      r_snap  <= n_snap;
      r_cnt   <= n_cnt;
      r_idx   <= n_idx;
      r_max   <= n_max;
      r_mask  <= n_mask;
      r_p     <= n_p;
      r_pos   <= n_pos;
      r_tick  <= n_tick;
      r_step  <= n_step;
      r_beep  <= n_beep;
      r_blk   <= n_blk;
      r_phase <= n_phase;
      r_win   <= n_win;
      r_dig   <= n_dig;
      r_led   <= n_led;
      r_buz   <= n_buz;
      r_rv    <= n_rv;
    end
  end

  assign digits       = r_dig;
  assign led          = r_led;
  assign buzzer       = r_buz;
  assign result_valid = r_rv;

endmodule

// File: tb/tb_result_view.sv
// tb_result_view: directed and random stimulus for result_view,
// checked every cycle against a timeline model of the display.
module tb_result_view;

  localparam int MP  = 4;
  localparam int SWD = 7;
  localparam int TC  = 4;
  localparam int ST  = 2;
  localparam int BT  = 3;
  localparam int VID = 2;
  localparam int L   = ST * TC;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        view;
  logic [2:0]        player_count;
  logic [MP*SWD-1:0] scores;
  logic [31:0]       digits;
  logic [23:0]       led;
  logic              buzzer;
  logic              result_valid;

  int errors = 0;
  int checks = 0;

  bit m_active = 1'b0;
  int m_n      = 0;
  int m_cnt    = 0;
  int m_sc [MP];

  result_view #(
    .MAX_PLAYERS(MP), .SCORE_W(SWD), .TICK_CYCLES(TC),
    .STEP_TICKS(ST), .BEEP_TICKS(BT), .VIEW_ID(VID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .view(view),
    .player_count(player_count), .scores(scores),
    .digits(digits), .led(led), .buzzer(buzzer),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int clampv(input int s);
    return (s > 99) ? 99 : s;
  endfunction

  function automatic logic [MP*SWD-1:0] pk(input int a, input int b,
                                           input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  function automatic logic [MP*SWD-1:0] rnd_scores();
    logic [MP*SWD-1:0] s;
    int v;
    s = '0;
    for (int i = 0; i < MP; i++) begin
      case ($urandom_range(0, 5))
        0: v = 0;
        1: v = 50;
        2: v = 99;
        3: v = 127;
        default: v = int'($urandom_range(0, 127));
      endcase
      s[i*SWD +: SWD] = 7'(v);
    end
    return s;
  endfunction

  // Model: cycles elapsed since the block left IDLE, plus the snapshot.
  task automatic model_step();
    if (!rst_n) m_active = 1'b0;
    else if (!m_active) begin
      if (view == 3'(VID)) begin
        m_active = 1'b1;
        m_n      = 0;
      end
    end else if (view != 3'(VID)) m_active = 1'b0;
    else begin
      if (m_n == 0) begin
        m_cnt = (int'(player_count) > MP) ? MP : int'(player_count);
        for (int i = 0; i < MP; i++)
          m_sc[i] = int'(scores[i*SWD +: SWD]);
      end
      m_n++;
    end
  endtask

  task automatic model_out(output logic [31:0] d, output logic [23:0] l,
                           output logic b, output logic v);
    int s, q, p, pos, r, mx, c, nw, win;
    int wl[$];
    logic [3:0] dg [8];
    d = '1;
    l = '0;
    b = 1'b0;
    v = 1'b0;
    for (int k = 0; k < 8; k++) dg[k] = 4'hF;
    if (m_active && m_n > 0) begin
      if (m_cnt == 0) v = 1'b1;
      else if (m_n > m_cnt) begin
        s = m_n - m_cnt - 1;
        q = s / L;
        if (q < m_cnt * 6) begin
          p   = q / 6 + 1;
          pos = q % 6;
          if (pos < 5) begin
            c           = clampv(m_sc[p-1]);
            dg[pos]     = 4'(p);
            dg[pos + 2] = 4'(c / 10);
            dg[pos + 3] = 4'(c % 10);
          end
        end else begin
          r  = s - m_cnt * 6 * L;
          mx = -1;
          for (int i = 0; i < m_cnt; i++)
            if (m_sc[i] > mx) mx = m_sc[i];
          for (int i = 0; i < m_cnt; i++)
            if (m_sc[i] == mx) wl.push_back(i + 1);
          nw    = wl.size();
          win   = wl[(r / L) % nw];
          c     = clampv(mx);
          dg[4] = 4'(win);
          dg[6] = 4'(c / 10);
          dg[7] = 4'(c % 10);
          if (nw > 1) dg[0] = 4'(nw);
          if (((r / TC) / 5) % 2 == 0)
            foreach (wl[i]) l[wl[i] - 1] = 1'b1;
          b = ((r / TC) < BT);
          v = 1'b1;
        end
      end
    end
    for (int k = 0; k < 8; k++) d[4*k +: 4] = dg[k];
  endtask

  always @(posedge clk) begin
    logic [31:0] ed;
    logic [23:0] el;
    logic        eb;
    logic        ev;
    model_step();
    #1;
    model_out(ed, el, eb, ev);
    chk("digits", digits, ed);
    chk("led", 32'(led), 32'(el));
    chk("buzzer", 32'(buzzer), 32'(eb));
    chk("result_valid", 32'(result_valid), 32'(ev));
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    rst_n        = 1'b0;
    view         = 3'd0;
    player_count = 3'd0;
    scores       = '0;
    go(2);
    chk("rst_digits", digits, 32'hFFFF_FFFF);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_buzzer", 32'(buzzer), 32'h0);
    chk("rst_valid", 32'(result_valid), 32'h0);
    #1; rst_n = 1'b1;
    go(2);
    chk("idle_digits", digits, 32'hFFFF_FFFF);

    // Clear winner, 4 players
    #1; scores = pk(12, 45, 7, 30); player_count = 3'd4; view = 3'(VID);
    go(1);
    chk("latch_valid", 32'(result_valid), 32'h0);
    go(5);
    chk("a_scroll", digits, 32'hFFFF_21F1);
    go(192);
    chk("a_result", digits, 32'h54F2_FFFF);
    chk("a_led_on", 32'(led), 32'h2);
    chk("a_buzz_on", 32'(buzzer), 32'h1);
    go(12);
    chk("a_buzz_off", 32'(buzzer), 32'h0);
    go(8);
    chk("a_led_off", 32'(led), 32'h0);
    #1; view = 3'd0;
    go(1);
    chk("a_idle", digits, 32'hFFFF_FFFF);

    // Tie between players 1 and 3
    #1; scores = pk(50, 10, 50, 0); player_count = 3'd3; view = 3'(VID);
    go(149);
    chk("b_win1", digits, 32'h05F1_FFF2);
    chk("b_led", 32'(led), 32'h5);
    go(8);
    chk("b_win3", digits, 32'h05F3_FFF2);
    go(8);
    chk("b_win1_again", digits, 32'h05F1_FFF2);
    #1; view = 3'd0;
    go(2);

    // No players
    #1; player_count = 3'd0; view = 3'(VID);
    go(2);
    chk("c_valid", 32'(result_valid), 32'h1);
    chk("c_blank", digits, 32'hFFFF_FFFF);
    chk("c_buzz", 32'(buzzer), 32'h0);
    go(10);
    chk("c_hold", 32'(result_valid), 32'h1);
    #1; view = 3'd0;
    go(1);
    chk("c_leave", 32'(result_valid), 32'h0);

    // Count above MAX_PLAYERS, clamped score, reset in RESULT
    #1; scores = pk(3, 3, 3, 120); player_count = 3'd7; view = 3'(VID);
    go(150);
    chk("d_scroll_p4", digits, 32'hFFFF_99F4);
    go(48);
    chk("d_result", digits, 32'h99F4_FFFF);
    chk("d_led", 32'(led), 32'h8);
    go(3);
    chk("d_buzz", 32'(buzzer), 32'h1);
    #1; rst_n = 1'b0;
    #1;
    chk("d_rst_buz", 32'(buzzer), 32'h0);
    chk("d_rst_led", 32'(led), 32'h0);
    chk("d_rst_valid", 32'(result_valid), 32'h0);
    chk("d_rst_dig", digits, 32'hFFFF_FFFF);
    go(2);
    #1; rst_n = 1'b1;
    go(8);
    #1; view = 3'd0;
    go(1);

    // Leaving mid-scroll and restarting with new scores
    #1; scores = pk(10, 20, 30, 40); player_count = 3'd2; view = 3'(VID);
    go(4);
    chk("e_scroll", digits, 32'hFFFF_01F1);
    go(10);
    chk("e_pos1", digits, 32'hFFF0_1F1F);
    #1; view = 3'd3;
    go(1);
    chk("e_leave", digits, 32'hFFFF_FFFF);
    chk("e_leave_valid", 32'(result_valid), 32'h0);
    #1; scores = pk(88, 5, 5, 5); view = 3'(VID);
    go(4);
    chk("e_restart", digits, 32'hFFFF_88F1);
    #1; view = 3'd0;
    go(2);

    // Random episodes
    for (int ep = 0; ep < 30; ep++) begin
      #1;
      scores       = rnd_scores();
      player_count = 3'($urandom_range(0, 7));
      view         = 3'(VID);
      len          = int'($urandom_range(5, 400));
      for (int c = 0; c < len; c++) begin
        go(1);
        #1;
        if ($urandom_range(0, 19) == 0) scores = rnd_scores();
        if ($urandom_range(0, 19) == 0)
          player_count = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 299) == 0) view = 3'($urandom_range(0, 7));
        rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      end
      view  = 3'd0;
      rst_n = 1'b1;
      go(2);
    end

    go(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
